// File: rtl/synth_cmd_rx.sv
// Serial command receiver: decodes UART bytes into Synthia key vector and button pulses.
// Optional idle key auto-release is built when SYNTH_CMD_WATCHDOG_EN is defined.
module synth_cmd_rx #(
    parameter int unsigned PRESS_CYCLES   = 12000,
    parameter int unsigned TIMEOUT_CYCLES = 12000000
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [7:0]  rxdata,
    input  logic        rxready,
    output logic        rxclk,
    output logic [12:0] keys,
    output logic        modes,
    output logic        octaves,
    output logic        cmd_err
);

    localparam int unsigned PressW = $clog2(PRESS_CYCLES + 1);
    localparam logic [PressW-1:0] PressLoad = PressW'(PRESS_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StWaitOn,
        StWaitOff
    } state_e;

    state_e              state_q, state_d;
    logic [12:0]         keys_q, keys_d;
    logic                rxclk_q;
    logic                err_q, err_d;
    logic [PressW-1:0]   press_cnt_q, press_cnt_d;
    logic                press_sel_q, press_sel_d;
    logic                accept;
    logic                press_busy;
    logic                wd_fire;

    // rxclk_q blocks the byte still presented during its own acknowledge cycle
    assign accept     = rxready && !rxclk_q;
    assign press_busy = (press_cnt_q != '0);

    always_comb begin
        state_d     = state_q;
        keys_d      = keys_q;
        err_d       = 1'b0;
        press_cnt_d = press_cnt_q;
        press_sel_d = press_sel_q;

        if (press_busy) begin
            press_cnt_d = press_cnt_q - PressW'(1);
        end

        if (accept) begin
            if (rxdata[7]) begin
                // A status byte aborts any pending note command before being decoded
                if (state_q != StIdle) begin
                    err_d = 1'b1;
                end
                state_d = StIdle;
                case (rxdata)
                    8'h90: state_d = StWaitOn;
                    8'h80: state_d = StWaitOff;
                    8'hB0, 8'hB1: begin
                        if (press_busy) begin
                            err_d = 1'b1;
                        end else begin
                            press_cnt_d = PressLoad;
                            press_sel_d = rxdata[0];
                        end
                    end
                    8'hFF:   keys_d = '0;
                    default: err_d = 1'b1;
                endcase
            end else begin
                state_d = StIdle;
                if (state_q == StIdle || rxdata[6:0] > 7'd12) begin
                    err_d = 1'b1;
                end else if (state_q == StWaitOn) begin
                    keys_d[rxdata[3:0]] = 1'b1;
                end else begin
                    keys_d[rxdata[3:0]] = 1'b0;
                end
            end
        end else if (wd_fire) begin
            keys_d = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= StIdle;
            keys_q      <= '0;
            rxclk_q     <= 1'b0;
            err_q       <= 1'b0;
            press_cnt_q <= '0;
            press_sel_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            keys_q      <= keys_d;
            rxclk_q     <= accept;
            err_q       <= err_d;
            press_cnt_q <= press_cnt_d;
            press_sel_q <= press_sel_d;
        end
    end

`ifdef SYNTH_CMD_WATCHDOG_EN
    localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IdleW-1:0] IdleMax = IdleW'(TIMEOUT_CYCLES);

    logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;

    // Saturating idle counter; fires once on the edge it reaches the limit
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        wd_fire    = 1'b0;
        if (accept) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != IdleMax) begin
            idle_cnt_d = idle_cnt_q + IdleW'(1);
            wd_fire    = (idle_cnt_d == IdleMax) && (keys_q != '0);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign wd_fire        = 1'b0;
`endif

    assign rxclk   = rxclk_q;
    assign keys    = keys_q;
    assign cmd_err = err_q;
    assign modes   = press_busy && !press_sel_q;
    assign octaves = press_busy && press_sel_q;

endmodule

// File: tb/tb_synth_cmd_rx.sv
// Bench for synth_cmd_rx: directed byte table, press/reset sequences and random bytes
// checked every cycle against an interval-based reference model.
module tb_synth_cmd_rx;

    localparam int P = 8;
    localparam int T = 100;

    logic        clk;
    logic        n_rst;
    logic [7:0]  rxdata;
    logic        rxready;
    logic        rxclk;
    logic [12:0] keys;
    logic        modes;
    logic        octaves;
    logic        cmd_err;

    synth_cmd_rx #(
        .PRESS_CYCLES  (P),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .rxdata (rxdata),
        .rxready(rxready),
        .rxclk  (rxclk),
        .keys   (keys),
        .modes  (modes),
        .octaves(octaves),
        .cmd_err(cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit mon_en = 0;

    // Reference model state
    int          pending;     // 0 none, 1 note-on, 2 note-off
    logic [12:0] exp_keys;
    int          ack_cyc;
    int          err_cyc;
    bit          press_valid;
    int          press_start;
    bit          press_sel;
    int          last_acc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [12:0] model_keys(input int c);
`ifdef SYNTH_CMD_WATCHDOG_EN
        if (c >= last_acc + T) return 13'h0;
`endif
        return exp_keys;
    endfunction

    function automatic bit press_on(input int c);
        return press_valid && c >= press_start && c < press_start + P;
    endfunction

    task automatic model_reset();
        pending     = 0;
        exp_keys    = '0;
        ack_cyc     = -10;
        err_cyc     = -10;
        press_valid = 0;
        press_start = 0;
        press_sel   = 0;
    endtask

    // Apply one byte sampled on edge s to the model
    task automatic model_byte(input logic [7:0] b, input int s);
        bit err = 0;
        exp_keys = model_keys(s - 1);
        if (b[7]) begin
            if (pending != 0) err = 1;
            pending = 0;
            if (b == 8'h90) pending = 1;
            else if (b == 8'h80) pending = 2;
            else if (b == 8'hB0 || b == 8'hB1) begin
                if (press_on(s - 1)) err = 1;
                else begin
                    press_valid = 1;
                    press_start = s;
                    press_sel   = b[0];
                end
            end else if (b == 8'hFF) exp_keys = '0;
            else err = 1;
        end else begin
            if (pending == 0 || b > 8'd12) err = 1;
            else if (pending == 1) exp_keys = exp_keys | (13'h1 << b);
            else exp_keys = exp_keys & ~(13'h1 << b);
            pending = 0;
        end
        ack_cyc  = s;
        last_acc = s;
        if (err) err_cyc = s;
    endtask

    // Present a byte for one edge; returns at the negedge of its acknowledge cycle
    task automatic send(input logic [7:0] b);
        int s;
        @(negedge clk);
        rxdata  = b;
        rxready = 1'b1;
        s = cyc + 1;
        @(posedge clk);
        #1;
        rxready = 1'b0;
        model_byte(b, s);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        mon_en  = 0;
        n_rst   = 1'b0;
        rxready = 1'b0;
        #1;
        check("rst_keys", keys, 0);
        check("rst_modes", modes, 0);
        check("rst_octaves", octaves, 0);
        check("rst_rxclk", rxclk, 0);
        check("rst_cmd_err", cmd_err, 0);
        model_reset();
        repeat (2) @(negedge clk);
        n_rst    = 1'b1;
        last_acc = cyc;
        @(posedge clk);
        #1;
        mon_en = 1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("mon_rxclk", rxclk, (cyc == ack_cyc));
            check("mon_cmd_err", cmd_err, (cyc == err_cyc));
            check("mon_keys", keys, model_keys(cyc));
            check("mon_modes", modes, press_on(cyc) && !press_sel);
            check("mon_octaves", octaves, press_on(cyc) && press_sel);
        end
    end

    typedef struct {
        logic [7:0]  b;
        logic        err;
        logic [12:0] k;
    } vec_t;

    vec_t vec[16];

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [7:0] b;
        vec[0]  = '{8'h90, 1'b0, 13'h0000};
        vec[1]  = '{8'h05, 1'b0, 13'h0020};
        vec[2]  = '{8'h90, 1'b0, 13'h0020};
        vec[3]  = '{8'h0C, 1'b0, 13'h1020};
        vec[4]  = '{8'h80, 1'b0, 13'h1020};
        vec[5]  = '{8'h0C, 1'b0, 13'h0020};
        vec[6]  = '{8'h90, 1'b0, 13'h0020};
        vec[7]  = '{8'h0D, 1'b1, 13'h0020};
        vec[8]  = '{8'h05, 1'b1, 13'h0020};
        vec[9]  = '{8'h90, 1'b0, 13'h0020};
        vec[10] = '{8'h80, 1'b1, 13'h0020};
        vec[11] = '{8'h05, 1'b0, 13'h0000};
        vec[12] = '{8'hA5, 1'b1, 13'h0000};
        vec[13] = '{8'h90, 1'b0, 13'h0000};
        vec[14] = '{8'h03, 1'b0, 13'h0008};
        vec[15] = '{8'hFF, 1'b0, 13'h0000};

        n_rst   = 1'b0;
        rxready = 1'b0;
        rxdata  = 8'h00;
        model_reset();
        do_reset();

        for (int i = 0; i < 16; i++) begin
            send(vec[i].b);
            check("vec_rxclk", rxclk, 1);
            check("vec_err", cmd_err, vec[i].err);
            check("vec_keys", keys, vec[i].k);
        end

        // Abort of pending note-on by note-off with key 3 held
        send(8'h90); send(8'h03);
        send(8'h90); send(8'h80);
        check("abort_err", cmd_err, 1);
        send(8'h03);
        check("abort_clear_err", cmd_err, 0);
        check("abort_clear_keys", keys, 0);

        // All keys on, then clear-all
        for (int k = 0; k < 13; k++) begin
            send(8'h90);
            b = 8'(k);
            send(b);
        end
        check("all_keys", keys, 13'h1FFF);
        send(8'hFF);
        check("clear_all", keys, 0);

        // Press length
        repeat (3) @(negedge clk);
        send(8'hB0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (modes === 1'b1) n++;
            @(negedge clk);
        end
        check("modes_len", n, P);

        // Retrigger attempt during a press
        send(8'hB0);
        repeat (2) @(negedge clk);
        send(8'hB1);
        check("retrig_err", cmd_err, 1);
        check("retrig_oct", octaves, 0);
        repeat (12) @(negedge clk);

        // Reset between note-on and its data byte
        send(8'h90);
        do_reset();
        send(8'h03);
        check("rst_mid_err", cmd_err, 1);
        check("rst_mid_keys", keys, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    b = 8'h90;
                2:       b = 8'h80;
                3:       b = 8'hB0;
                4:       b = 8'hB1;
                5:       b = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'h90;
                9:       b = 8'($urandom_range(0, 255));
                default: b = 8'($urandom_range(0, 15));
            endcase
            send(b);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (i % 150 == 149) do_reset();
        end

        // Idle behaviour with a key held
        send(8'hFF);
        send(8'h90);
        send(8'h01);
        repeat (120) @(negedge clk);
`ifdef SYNTH_CMD_WATCHDOG_EN
        check("idle_keys", keys, 13'h0000);
`else
        check("idle_keys", keys, 13'h0002);
`endif

        mon_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
